// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: the master issues divide requests,
// the slave (the divider) returns quotient, remainder and status.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic                   start;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   div_zero;
  logic                   overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient
// bit per clock, with divide-by-zero and quotient-overflow early exits.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic             accept_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             borrow_s;
  logic             qbit_s;

  // Next-state, datapath step and output register inputs
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    shf_d    = shf_q;
    dvs_d    = dvs_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    ov_d     = ov_q;

    accept_s = bus.start && (state_q != CALC);
    trial_s  = {rem_q[WIDTH-1:0], shf_q[WIDTH-1]};
    {borrow_s, diff_s} = {1'b0, trial_s} - {2'b00, dvs_q};
    // A set partial-remainder MSB means the shifted value exceeds W+1 bits,
    // so the subtraction always succeeds regardless of the borrow.
    qbit_s   = rem_q[WIDTH] | ~borrow_s;

    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (accept_s) begin
          if (bus.divisor == {WIDTH{1'b0}}) begin
            dz_d    = 1'b1;
            ov_d    = 1'b0;
            quot_d  = {WIDTH{1'b1}};
            remo_d  = {WIDTH{1'b0}};
            done_d  = 1'b1;
            state_d = DONE;
          end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
            dz_d    = 1'b0;
            ov_d    = 1'b1;
            quot_d  = {WIDTH{1'b1}};
            remo_d  = {WIDTH{1'b0}};
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            ov_d    = 1'b0;
            rem_d   = {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
            shf_d   = bus.dividend[WIDTH-1:0];
            dvs_d   = bus.divisor;
            cnt_d   = {CW{1'b0}};
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = qbit_s ? diff_s : trial_s;
        shf_d = {shf_q[WIDTH-2:0], qbit_s};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          quot_d  = shf_d;
          remo_d  = rem_d[WIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= {(WIDTH+1){1'b0}};
      shf_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      remo_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = remo_q;
  assign bus.div_zero  = dz_q;
  assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider, checked against a plain
// arithmetic reference (integer / and %) kept in the bench.
module tb_seq_divider;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.WIDTH(W)) bus();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned division on wide integers, errors by definition.
  task automatic model(input logic [31:0] dd, input logic [15:0] dv,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov, output int lat);
    longint unsigned qq;
    dz = 1'b0; ov = 1'b0;
    if (dv == 16'd0) begin
      dz = 1'b1; q = 16'hFFFF; r = 16'd0; lat = 0;
    end else begin
      qq = longint'(dd) / longint'(dv);
      if (qq > 64'd65535) begin
        ov = 1'b1; q = 16'hFFFF; r = 16'd0; lat = 0;
      end else begin
        q = qq[15:0]; r = 16'(dd % 32'(dv)); lat = W;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] dv);
    logic [15:0] eq, er;
    logic        edz, eov;
    int          elat, lat, busy_cnt, both;
    model(dd, dv, eq, er, edz, eov, elat);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv;
    @(posedge clk); #1;
    lat = 0; busy_cnt = 0; both = 0;
    while (1) begin
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) both++;
      if (lat == 0) begin
        bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = 16'($urandom);
      end
      if (bus.done || lat >= 40) break;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(elat));
    check({tag, ".busy_and_done"}, 64'(both), 64'd0);
    check({tag, ".quotient"}, 64'(bus.quotient), 64'(eq));
    check({tag, ".remainder"}, 64'(bus.remainder), 64'(er));
    check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(edz));
    check({tag, ".overflow"}, 64'(bus.overflow), 64'(eov));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, ".held_q"}, 64'(bus.quotient), 64'(eq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dd;
    logic [15:0] dv;
    int          done_at[$];
    int          guard;

    rst_n = 1'b0; bus.start = 1'b0; bus.dividend = 32'd0; bus.divisor = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.quotient", 64'(bus.quotient), 64'd0);
    check("reset.remainder", 64'(bus.remainder), 64'd0);
    check("reset.flags", 64'({bus.div_zero, bus.overflow}), 64'd0);
    rst_n = 1'b1;

    run_op("d1000_7", 32'd1000, 16'd7);
    run_op("maxprod", 32'hFFFE0001, 16'hFFFF);
    run_op("divzero", 32'd1234, 16'd0);
    run_op("ovf_eq", 32'h00050000, 16'd5);
    run_op("ovf_gt", 32'h00060000, 16'd5);
    run_op("maxquot", 32'h0004FFFF, 16'd5);
    run_op("zero_dd", 32'd0, 16'd3);
    run_op("div_one", 32'h0000BEEF, 16'd1);

    for (int i = 0; i < 24; i++) begin
      case (i % 6)
        0: begin dv = 16'd0; dd = $urandom; end
        1: begin dv = 16'($urandom_range(1, 65535)); dd = {16'($urandom_range(32'(dv), 65535)), 16'($urandom)}; end
        default: begin
          dv = 16'($urandom_range(1, 65535));
          dd = {16'($urandom_range(0, 32'(dv) - 1)), 16'($urandom)};
        end
      endcase
      run_op($sformatf("rand%0d", i), dd, dv);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Continuous start: operands scrambled mid-calculation, restored for restart.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd9;
    for (int k = 1; k <= 52; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        done_at.push_back(k);
        check("b2b.quotient", 64'(bus.quotient), 64'd11);
        check("b2b.remainder", 64'(bus.remainder), 64'd1);
        check("b2b.busy_and_done", 64'(bus.busy), 64'd0);
      end
      if (bus.busy) begin
        bus.dividend = $urandom; bus.divisor = 16'($urandom);
      end else begin
        bus.dividend = 32'd100; bus.divisor = 16'd9;
      end
    end
    bus.start = 1'b0;
    check("b2b.pulse_count", 64'(done_at.size()), 64'd3);
    if (done_at.size() == 3) begin
      check("b2b.interval1", 64'(done_at[1] - done_at[0]), 64'd17);
      check("b2b.interval2", 64'(done_at[2] - done_at[1]), 64'd17);
    end
    guard = 0;
    while (!bus.done && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b2b.tail_done", 64'(bus.done), 64'd1);
    repeat (2) @(posedge clk);

    // Abort mid-calculation with an asynchronous reset.
    run_op("pre_abort", 32'h00301234, 16'h0100);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'h01234567; bus.divisor = 16'h8000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.quotient", 64'(bus.quotient), 64'd0);
    check("abort.remainder", 64'(bus.remainder), 64'd0);
    check("abort.flags", 64'({bus.div_zero, bus.overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("abort.no_done", 64'(bus.done), 64'd0);
    run_op("after_abort", 32'd65535, 16'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider, the inverse of the team's 16x16 combinational multiplier.
- Divides a 2*WIDTH-bit dividend (for example a multiplier product) by a WIDTH-bit divisor.
- Returns a WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock.
- Used wherever a product must be scaled back down, or a multiplier result checked on-chip.

Parameters:
WIDTH  16  divisor/quotient/remainder width; dividend width is 2*WIDTH; latency is WIDTH cycles

Ports:
clk        input   1          single clock, rising edge
rst_n      input   1          asynchronous active-low reset
start      input   1          request; sampled on rising clk when busy=0
dividend   input   2*WIDTH    captured on accepted start
divisor    input   WIDTH      captured on accepted start
busy       output  1          high while an operation is in progress
done       output  1          one-cycle pulse; quotient/remainder/flags valid from this cycle
quotient   output  WIDTH      result, held until the next accepted start
remainder  output  WIDTH      result, held until the next accepted start
div_zero   output  1          divisor was 0 (valid with done, held)
overflow   output  1          quotient would not fit in WIDTH bits (valid with done, held)

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy, done, quotient, remainder, div_zero, overflow all 0; iteration counter 0.
- States: IDLE, CALC, DONE. DONE lasts exactly one cycle, then returns to IDLE.
- Accept: start=1 at a rising edge while in IDLE or DONE (busy=0).
  - Operands are captured into internal registers.
  - Later changes on dividend/divisor have no effect.
  - start while busy=1 is ignored. No queuing.
- Error check at the accept edge, evaluated on the input operands:
  - divisor==0 -> div_zero=1, overflow=0.
  - Else if dividend[2W-1:W] >= divisor -> overflow=1, div_zero=0.
  - Either error: quotient=all ones, remainder=0, next state DONE.
  - done is high in the cycle after the accept edge; busy is never asserted.
- Normal case: flags cleared at the accept edge; state=CALC; busy=1; counter=0.
  - Partial remainder register is W+1 bits, loaded with dividend[2W-1:W].
  - Shift register is loaded with dividend[W-1:0].
- Each CALC edge performs one restoring step:
  - Shift the partial remainder left 1, bringing in the MSB of the shift register.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and shift 1 into the quotient LSB; otherwise restore and shift 0.
  - Increment the counter.
- On the WIDTH-th CALC edge (counter==WIDTH-1):
  - quotient and remainder outputs are registered.
  - State=DONE; busy=0; done=1 for one cycle.
  - done therefore rises exactly WIDTH cycles after the accept edge.
- Invariant on normal completion: dividend == quotient*divisor + remainder, and remainder < divisor.
- Outputs quotient/remainder/flags hold their values through IDLE until the next accepted start. They change only at an accept edge (errors) or at the completion edge.
- Back-to-back: start=1 during the DONE cycle is accepted; the new operation begins without an idle gap.
- Reset during CALC aborts immediately: all outputs 0, no done pulse. The first start after release behaves normally.
- done and busy are never high in the same cycle.
- All arithmetic is unsigned.

Test Plan:
- dividend=32'd1000, divisor=16'd7, start pulse -> busy=1 for 16 cycles; done 16 cycles after accept; quotient=142, remainder=6, flags 0.
- dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0, overflow=0. This inverts the multiplier's maximum product.
- divisor=0, dividend=32'd1234 -> done the cycle after accept; busy stays 0; div_zero=1; quotient=16'hFFFF; remainder=0.
- dividend=32'h00050000, divisor=16'd5 -> overflow=1, div_zero=0, quotient=16'hFFFF, remainder=0, done after 1 cycle.
- Hold start=1 continuously with dividend=32'd100, divisor=16'd9:
  - Changing operands mid-CALC does not affect the result.
  - Results are quotient=11, remainder=1.
  - Restart is accepted in the DONE cycle, giving done pulses every 17 cycles.
- Assert rst_n=0 asynchronously 8 cycles into a CALC -> busy, done, quotient and remainder immediately 0. After release, 32'd65535/16'd256 gives quotient=255, remainder=255.
